// File: rtl/bsg_mcl_endpoint_responder.sv
// bsg_mcl_endpoint_responder: word-addressed local memory endpoint that
// serves store and load request packets and returns load responses.
// Optional feature: define BSG_MCL_RESP_SKID_EN to add a 2-entry response
// FIFO so loads can be accepted back to back while responses drain.
module bsg_mcl_endpoint_responder #(
  parameter int mem_els_p = 256,
  parameter int x_cord_p  = 0,
  parameter int y_cord_p  = 0
) (
  input  logic         clk_main_a0,
  input  logic         rst_main_n,
  input  logic         req_v_i,
  input  logic [127:0] req_i,
  output logic         req_ready_o,
  output logic         resp_v_o,
  output logic [127:0] resp_o,
  input  logic         resp_ready_i,
  output logic [15:0]  err_cnt_o
);

  localparam int idx_w_lp = $clog2(mem_els_p);

  logic [31:0] req_addr;
  logic [7:0]  req_op;
  logic [7:0]  req_op_ex;
  logic [31:0] req_payload;
  logic [7:0]  req_src_y;
  logic [7:0]  req_src_x;
  logic [7:0]  req_y;
  logic [7:0]  req_x;

  assign req_addr    = req_i[111:80];
  assign req_op      = req_i[79:72];
  assign req_op_ex   = req_i[71:64];
  assign req_payload = req_i[63:32];
  assign req_src_y   = req_i[31:24];
  assign req_src_x   = req_i[23:16];
  assign req_y       = req_i[15:8];
  assign req_x       = req_i[7:0];

  logic unused_req;
  assign unused_req = ^{req_i[127:112], req_op_ex[7:4], req_addr[31:idx_w_lp]};

  logic                accept;
  logic                coord_ok;
  logic                in_range;
  logic                is_load;
  logic                is_store;
  logic                load_hit;
  logic                load_oob;
  logic                store_hit;
  logic                err_inc;
  logic [idx_w_lp-1:0] mem_idx;

  // Request classification; anything accepted that is not a good load/store is an error
  always_comb begin
    accept    = req_v_i & req_ready_o;
    coord_ok  = (req_x == 8'(x_cord_p)) && (req_y == 8'(y_cord_p));
    in_range  = req_addr < 32'(mem_els_p);
    is_load   = req_op == 8'h00;
    is_store  = req_op == 8'h01;
    load_hit  = accept & coord_ok & is_load & in_range;
    load_oob  = accept & coord_ok & is_load & ~in_range;
    store_hit = accept & coord_ok & is_store & in_range;
    err_inc   = accept & ~load_hit & ~store_hit;
    mem_idx   = req_addr[idx_w_lp-1:0];
  end

  function automatic logic [127:0] pack_resp(input logic [7:0]  pkt_type,
                                             input logic [31:0] data,
                                             input logic [31:0] load_id,
                                             input logic [7:0]  y_cord,
                                             input logic [7:0]  x_cord);
    return {40'h0, pkt_type, data, load_id, y_cord, x_cord};
  endfunction

  logic [31:0] mem_q [mem_els_p];
  logic [31:0] rd_data_q;

  // Byte-lane masked store and synchronous load read; contents survive reset
  always_ff @(posedge clk_main_a0) begin
    if (store_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (req_op_ex[i]) begin
          mem_q[mem_idx][8*i +: 8] <= req_payload[8*i +: 8];
        end
      end
    end
    if (load_hit) begin
      rd_data_q <= mem_q[mem_idx];
    end
  end

  logic [31:0] load_id_d, load_id_q;
  logic [7:0]  src_x_d, src_x_q;
  logic [7:0]  src_y_d, src_y_q;
  logic [15:0] err_cnt_d, err_cnt_q;

  // Remember who asked for an in-range load and bump the saturating error count
  always_comb begin
    load_id_d = load_id_q;
    src_x_d   = src_x_q;
    src_y_d   = src_y_q;
    err_cnt_d = err_cnt_q;
    if (load_hit) begin
      load_id_d = req_payload;
      src_x_d   = req_src_x;
      src_y_d   = req_src_y;
    end
    if (err_inc && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Load metadata and error counter registers
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) begin
      load_id_q <= '0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      load_id_q <= load_id_d;
      src_x_q   <= src_x_d;
      src_y_q   <= src_y_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;

`ifdef BSG_MCL_RESP_SKID_EN

  logic         stage_v_d, stage_v_q;
  logic [127:0] fifo0_d, fifo0_q;
  logic [127:0] fifo1_d, fifo1_q;
  logic [1:0]   fifo_cnt_d, fifo_cnt_q;
  logic         pop;
  logic [2:0]   occupancy;
  logic [127:0] stage_pkt;
  logic [127:0] oob_pkt;

  // Keep taking requests while queued plus in-flight responses leave room
  always_comb begin
    pop         = (fifo_cnt_q != 2'd0) & resp_ready_i;
    occupancy   = {1'b0, fifo_cnt_q} + {2'b0, stage_v_q} - {2'b0, pop};
    req_ready_o = rst_main_n && (occupancy < 3'd2);
    resp_v_o    = fifo_cnt_q != 2'd0;
    resp_o      = fifo0_q;
  end

  // Pop the head, then append the read-stage response ahead of any new out-of-range one
  always_comb begin
    stage_v_d  = load_hit;
    stage_pkt  = pack_resp(8'h01, rd_data_q, load_id_q, src_y_q, src_x_q);
    oob_pkt    = pack_resp(8'h02, 32'hDEADBEEF, req_payload, req_src_y, req_src_x);
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    fifo_cnt_d = fifo_cnt_q;
    if (pop) begin
      fifo0_d    = fifo1_q;
      fifo_cnt_d = fifo_cnt_d - 2'd1;
    end
    if (stage_v_q) begin
      if (fifo_cnt_d == 2'd0) fifo0_d = stage_pkt;
      else                    fifo1_d = stage_pkt;
      fifo_cnt_d = fifo_cnt_d + 2'd1;
    end
    if (load_oob) begin
      if (fifo_cnt_d == 2'd0) fifo0_d = oob_pkt;
      else                    fifo1_d = oob_pkt;
      fifo_cnt_d = fifo_cnt_d + 2'd1;
    end
  end

  // Read-stage valid and response FIFO registers
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) begin
      stage_v_q  <= 1'b0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      fifo_cnt_q <= '0;
    end else begin
      stage_v_q  <= stage_v_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

`else

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_RD = 2'd1,
    RESP    = 2'd2
  } state_e;

  state_e       state_d, state_q;
  logic [127:0] resp_d, resp_q;

  // State register; reset abandons any in-flight load
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next state: in-range loads wait a cycle for the memory, out-of-range go straight to RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_hit)      state_d = LOAD_RD;
        else if (load_oob) state_d = RESP;
      end
      LOAD_RD: state_d = RESP;
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs follow the state; the response is held in a register
  always_comb begin
    req_ready_o = rst_main_n && (state_q == IDLE);
    resp_v_o    = state_q == RESP;
    resp_o      = resp_q;
  end

  // Build the response packet on entry to RESP and hold it until handshake
  always_comb begin
    resp_d = resp_q;
    if ((state_q == IDLE) && load_oob) begin
      resp_d = pack_resp(8'h02, 32'hDEADBEEF, req_payload, req_src_y, req_src_x);
    end else if (state_q == LOAD_RD) begin
      resp_d = pack_resp(8'h01, rd_data_q, load_id_q, src_y_q, src_x_q);
    end
  end

  // Response packet register
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) resp_q <= '0;
    else             resp_q <= resp_d;
  end

`endif

endmodule

// File: tb/tb_bsg_mcl_endpoint_responder.sv
// tb_bsg_mcl_endpoint_responder: directed self-checking bench for the
// endpoint responder in its default build (BSG_MCL_RESP_SKID_EN undefined).
module tb_bsg_mcl_endpoint_responder;

  localparam int MEM_ELS = 256;
  localparam int XC = 1;
  localparam int YC = 2;

  logic         clk_main_a0;
  logic         rst_main_n;
  logic         req_v_i;
  logic [127:0] req_i;
  logic         req_ready_o;
  logic         resp_v_o;
  logic [127:0] resp_o;
  logic         resp_ready_i;
  logic [15:0]  err_cnt_o;

  int total = 0;
  int bad   = 0;
  int hsCount = 0;

  bsg_mcl_endpoint_responder #(
    .mem_els_p(MEM_ELS),
    .x_cord_p (XC),
    .y_cord_p (YC)
  ) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .req_v_i     (req_v_i),
    .req_i       (req_i),
    .req_ready_o (req_ready_o),
    .resp_v_o    (resp_v_o),
    .resp_o      (resp_o),
    .resp_ready_i(resp_ready_i),
    .err_cnt_o   (err_cnt_o)
  );

  // Free-running 10 ns clock
  initial clk_main_a0 = 1'b0;
  always #5 clk_main_a0 = ~clk_main_a0;

  // Count completed response handshakes outside reset
  always @(posedge clk_main_a0) begin
    if (rst_main_n && resp_v_o && resp_ready_i) hsCount <= hsCount + 1;
  end

  // Hard stop in case something wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mkResp(input logic [7:0] t, input logic [31:0] d,
                                          input logic [31:0] id, input logic [7:0] y,
                                          input logic [7:0] x);
    return {40'h0, t, d, id, y, x};
  endfunction

  // Present one request, wait (bounded) for ready, hold it across the accepting edge.
  // Returns 1 ns into the cycle after acceptance.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr,
                               input logic [7:0] opEx, input logic [31:0] payload,
                               input logic [7:0] srcX, input logic [7:0] srcY,
                               input logic [7:0] x, input logic [7:0] y);
    int k;
    req_i   = {16'h0, addr, op, opEx, payload, srcY, srcX, y, x};
    req_v_i = 1'b1;
    k = 0;
    while (!req_ready_o && k < 20) begin
      @(posedge clk_main_a0); #1;
      k++;
    end
    if (k == 20) checkOutput("ready_timeout", 128'(req_ready_o), 128'(1));
    @(posedge clk_main_a0); #1;
    req_v_i = 1'b0;
    req_i   = '0;
  endtask

  task automatic tick();
    @(posedge clk_main_a0); #1;
  endtask

  initial begin
    int hs0;
    logic seen;

    rst_main_n   = 1'b0;
    req_v_i      = 1'b0;
    req_i        = '0;
    resp_ready_i = 1'b1;
    repeat (3) tick();
    checkOutput("rst_ready", 128'(req_ready_o), 128'(0));
    checkOutput("rst_resp_v", 128'(resp_v_o), 128'(0));
    checkOutput("rst_resp", resp_o, 128'h0);
    checkOutput("rst_err", 128'(err_cnt_o), 128'(0));
    rst_main_n = 1'b1;
    #1;
    checkOutput("idle_ready", 128'(req_ready_o), 128'(1));

    // Full-word store then load back to back with N+2 latency
    applyStimulus(8'h01, 32'd5, 8'h0F, 32'hCAFEF00D, 8'd0, 8'd0, XC, YC);
    checkOutput("store_ready", 128'(req_ready_o), 128'(1));
    applyStimulus(8'h00, 32'd5, 8'h00, 32'h77, 8'd2, 8'd3, XC, YC);
    checkOutput("ld_n1_v", 128'(resp_v_o), 128'(0));
    checkOutput("ld_n1_ready", 128'(req_ready_o), 128'(0));
    tick();
    checkOutput("ld_n2_v", 128'(resp_v_o), 128'(1));
    checkOutput("ld_n2_resp", resp_o, mkResp(8'h01, 32'hCAFEF00D, 32'h77, 8'd3, 8'd2));
    tick();
    checkOutput("ld_n3_v", 128'(resp_v_o), 128'(0));
    checkOutput("ld_n3_ready", 128'(req_ready_o), 128'(1));

    // Byte-lane masking
    applyStimulus(8'h01, 32'd9, 8'h0F, 32'hFFFFFFFF, 8'd0, 8'd0, XC, YC);
    applyStimulus(8'h01, 32'd9, 8'h05, 32'h00000000, 8'd0, 8'd0, XC, YC);
    applyStimulus(8'h00, 32'd9, 8'h00, 32'h10, 8'd4, 8'd5, XC, YC);
    tick();
    checkOutput("mask_resp", resp_o, mkResp(8'h01, 32'hFF00FF00, 32'h10, 8'd5, 8'd4));
    tick();

    // Backpressure: response held stable for 5 cycles, single handshake on release
    resp_ready_i = 1'b0;
    applyStimulus(8'h00, 32'd5, 8'h00, 32'h55, 8'd6, 8'd7, XC, YC);
    tick();
    hs0 = hsCount;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_resp_%0d", i), resp_o, mkResp(8'h01, 32'hCAFEF00D, 32'h55, 8'd7, 8'd6));
      checkOutput($sformatf("bp_v_%0d", i), 128'(resp_v_o), 128'(1));
      checkOutput($sformatf("bp_ready_%0d", i), 128'(req_ready_o), 128'(0));
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    checkOutput("bp_after_v", 128'(resp_v_o), 128'(0));
    repeat (3) tick();
    checkOutput("bp_hs_count", 128'(hsCount - hs0), 128'(1));

    // Out-of-range load answers at N+1 with DEADBEEF
    applyStimulus(8'h00, 32'(MEM_ELS), 8'h00, 32'h99, 8'd1, 8'd1, XC, YC);
    checkOutput("oob_v", 128'(resp_v_o), 128'(1));
    checkOutput("oob_resp", resp_o, mkResp(8'h02, 32'hDEADBEEF, 32'h99, 8'd1, 8'd1));
    checkOutput("oob_err", 128'(err_cnt_o), 128'(1));
    tick();
    checkOutput("oob_done_v", 128'(resp_v_o), 128'(0));

    // Reset while in RESP discards the pending response
    resp_ready_i = 1'b0;
    applyStimulus(8'h00, 32'd5, 8'h00, 32'h42, 8'd2, 8'd2, XC, YC);
    tick();
    checkOutput("rr_in_resp", 128'(resp_v_o), 128'(1));
    rst_main_n = 1'b0;
    #1;
    checkOutput("rr_ready_low", 128'(req_ready_o), 128'(0));
    @(posedge clk_main_a0); #1;
    checkOutput("rr_v", 128'(resp_v_o), 128'(0));
    checkOutput("rr_err", 128'(err_cnt_o), 128'(0));
    checkOutput("rr_resp", resp_o, 128'h0);
    rst_main_n   = 1'b1;
    resp_ready_i = 1'b1;
    hs0 = hsCount;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (resp_v_o) seen = 1'b1;
      tick();
    end
    checkOutput("rr_no_resp", 128'(seen), 128'(0));
    checkOutput("rr_no_hs", 128'(hsCount - hs0), 128'(0));

    // Memory survives reset
    applyStimulus(8'h00, 32'd5, 8'h00, 32'h1234, 8'd0, 8'd0, XC, YC);
    tick();
    checkOutput("keep_mem", resp_o, mkResp(8'h01, 32'hCAFEF00D, 32'h1234, 8'd0, 8'd0));
    tick();

    // Wrong X coordinate: dropped, no response, error counted
    applyStimulus(8'h00, 32'd5, 8'h00, 32'h1, 8'd0, 8'd0, XC + 1, YC);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (resp_v_o) seen = 1'b1;
      tick();
    end
    checkOutput("badx_no_resp", 128'(seen), 128'(0));
    checkOutput("badx_err", 128'(err_cnt_o), 128'(1));
    checkOutput("badx_ready", 128'(req_ready_o), 128'(1));

    // Unknown op, out-of-range store and wrong Y each count one error
    applyStimulus(8'h05, 32'd3, 8'h0F, 32'h1, 8'd0, 8'd0, XC, YC);
    checkOutput("badop_err", 128'(err_cnt_o), 128'(2));
    checkOutput("badop_v", 128'(resp_v_o), 128'(0));
    applyStimulus(8'h01, 32'(MEM_ELS + 44), 8'h0F, 32'hABCDABCD, 8'd0, 8'd0, XC, YC);
    checkOutput("oobst_err", 128'(err_cnt_o), 128'(3));
    applyStimulus(8'h01, 32'd5, 8'h0F, 32'h11111111, 8'd0, 8'd0, XC, YC + 1);
    checkOutput("bady_err", 128'(err_cnt_o), 128'(4));
    applyStimulus(8'h00, 32'd5, 8'h00, 32'h2, 8'd0, 8'd0, XC, YC);
    tick();
    checkOutput("dropped_store_nowrite", resp_o, mkResp(8'h01, 32'hCAFEF00D, 32'h2, 8'd0, 8'd0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
